// File: rtl/sap1_pkg.sv
// sap1_pkg: shared SAP-1 opcodes, T-state encoding and control-word type
package sap1_pkg;

    localparam logic [3:0] OP_LDA  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_OUT  = 4'b0100;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T1     = 6'b000001;
    localparam logic [5:0] T2     = 6'b000010;
    localparam logic [5:0] T3     = 6'b000100;
    localparam logic [5:0] T4     = 6'b001000;
    localparam logic [5:0] T5     = 6'b010000;
    localparam logic [5:0] T6     = 6'b100000;

    typedef enum logic {
        RUN,
        HALTED
    } run_state_e;

    typedef struct packed {
        logic pc_increment;
        logic pc_enable_output;
        logic mar_enable_input;
        logic ram_enable_output;
        logic ir_enable_input;
        logic ir_enable_output;
        logic a_enable_input;
        logic a_enable_output;
        logic b_enable_input;
        logic out_enable_input;
        logic alu_enable_output;
        logic alu_sub;
    } ctrl_t;

    // Anything that is not a defined instruction executes as a no-op
    function automatic logic is_nop(input logic [3:0] op);
        return !(op inside {OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HALT});
    endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: one-hot T1..T6 ring with restart-to-T1 and hold-at-zero
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic       advance,
    input  logic       restart,
    input  logic       hold,
    output logic [5:0] t_state
);

    // Reset wins, then hold parks the ring at zero, then restart, then rotate
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            t_state <= T1;
        else if (hold)
            t_state <= T_NONE;
        else if (restart)
            t_state <= T1;
        else if (advance)
            t_state <= {t_state[4:0], t_state[5]};
    end

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 control sequencer; define SAP1_EARLY_RETIRE_EN to end short instructions early
module sap1_controller
    import sap1_pkg::*;
(
    input  logic       Clock,
    input  logic       Reset_n,
    input  logic [3:0] opcode,
    output logic       pc_increment,
    output logic       pc_enable_output,
    output logic       mar_enable_input,
    output logic       ram_enable_output,
    output logic       ir_enable_input,
    output logic       ir_enable_output,
    output logic       a_enable_input,
    output logic       a_enable_output,
    output logic       b_enable_input,
    output logic       out_enable_input,
    output logic       alu_enable_output,
    output logic       alu_sub,
    output logic [5:0] t_state,
    output logic       halted
);

    run_state_e state, state_nx;
    ctrl_t      c;
    logic       halt_now, restart;
    logic       is_alu;

    assign halted   = (state == HALTED);
    assign halt_now = (state == RUN) && (t_state == T4) && (opcode == OP_HALT);
    assign is_alu   = (opcode == OP_ADD) || (opcode == OP_SUB);

`ifdef SAP1_EARLY_RETIRE_EN
    assign restart = ((t_state == T5) && (opcode == OP_LDA)) ||
                     ((t_state == T4) && (opcode == OP_OUT)) ||
                     ((t_state == T3) && is_nop(opcode));
`else
    assign restart = (t_state == T6);
`endif

    sap1_ring_counter u_ring (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .advance (1'b1),
        .restart (restart),
        .hold    (halt_now || halted),
        .t_state (t_state)
    );

    // Run/halt state register; only reset leaves HALTED
    always_ff @(posedge Clock) begin
        if (!Reset_n)
            state <= RUN;
        else
            state <= state_nx;
    end

    // Enter HALTED on the edge that ends T4 of a HALT
    always_comb begin
        state_nx = state;
        if (halt_now)
            state_nx = HALTED;
    end

    // Control word decode from T-state and opcode; silent in reset and halt
    always_comb begin
        c = '0;
        if (Reset_n && !halted) begin
            case (t_state)
                T1: begin
                    c.pc_enable_output = 1'b1;
                    c.mar_enable_input = 1'b1;
                end
                T2: c.pc_increment = 1'b1;
                T3: begin
                    c.ram_enable_output = 1'b1;
                    c.ir_enable_input   = 1'b1;
                end
                T4: begin
                    c.ir_enable_output = (opcode == OP_LDA) || is_alu;
                    c.mar_enable_input = (opcode == OP_LDA) || is_alu;
                    c.a_enable_output  = (opcode == OP_OUT);
                    c.out_enable_input = (opcode == OP_OUT);
                end
                T5: begin
                    c.ram_enable_output = (opcode == OP_LDA) || is_alu;
                    c.a_enable_input    = (opcode == OP_LDA);
                    c.b_enable_input    = is_alu;
                    c.alu_sub           = (opcode == OP_SUB);
                end
                T6: begin
                    c.alu_enable_output = is_alu;
                    c.a_enable_input    = is_alu;
                    c.alu_sub           = (opcode == OP_SUB);
                end
                default: c = '0;
            endcase
        end
    end

    assign pc_increment      = c.pc_increment;
    assign pc_enable_output  = c.pc_enable_output;
    assign mar_enable_input  = c.mar_enable_input;
    assign ram_enable_output = c.ram_enable_output;
    assign ir_enable_input   = c.ir_enable_input;
    assign ir_enable_output  = c.ir_enable_output;
    assign a_enable_input    = c.a_enable_input;
    assign a_enable_output   = c.a_enable_output;
    assign b_enable_input    = c.b_enable_input;
    assign out_enable_input  = c.out_enable_input;
    assign alu_enable_output = c.alu_enable_output;
    assign alu_sub           = c.alu_sub;

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: directed and random-stream checks of the SAP-1 controller
module tb_sap1_controller;

    localparam logic [11:0] K_PCI  = 12'h800;
    localparam logic [11:0] K_PCO  = 12'h400;
    localparam logic [11:0] K_MARI = 12'h200;
    localparam logic [11:0] K_RAMO = 12'h100;
    localparam logic [11:0] K_IRI  = 12'h080;
    localparam logic [11:0] K_IRO  = 12'h040;
    localparam logic [11:0] K_AI   = 12'h020;
    localparam logic [11:0] K_AO   = 12'h010;
    localparam logic [11:0] K_BI   = 12'h008;
    localparam logic [11:0] K_OUTI = 12'h004;
    localparam logic [11:0] K_ALUO = 12'h002;
    localparam logic [11:0] K_SUB  = 12'h001;

`ifdef SAP1_EARLY_RETIRE_EN
    localparam int LDA_LEN = 5;
    localparam int OUT_LEN = 4;
    localparam int NOP_LEN = 3;
`else
    localparam int LDA_LEN = 6;
    localparam int OUT_LEN = 6;
    localparam int NOP_LEN = 6;
`endif

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic [3:0]  opcode = 4'h0;
    logic        pc_increment, pc_enable_output, mar_enable_input, ram_enable_output;
    logic        ir_enable_input, ir_enable_output, a_enable_input, a_enable_output;
    logic        b_enable_input, out_enable_input, alu_enable_output, alu_sub;
    logic [5:0]  t_state;
    logic        halted;
    logic [11:0] ctl;
    logic [11:0] e [6];
    int          checks = 0;
    int          errors = 0;

    always #5 Clock = ~Clock;

    assign ctl = {pc_increment, pc_enable_output, mar_enable_input, ram_enable_output,
                  ir_enable_input, ir_enable_output, a_enable_input, a_enable_output,
                  b_enable_input, out_enable_input, alu_enable_output, alu_sub};

    sap1_controller dut (
        .Clock             (Clock),
        .Reset_n           (Reset_n),
        .opcode            (opcode),
        .pc_increment      (pc_increment),
        .pc_enable_output  (pc_enable_output),
        .mar_enable_input  (mar_enable_input),
        .ram_enable_output (ram_enable_output),
        .ir_enable_input   (ir_enable_input),
        .ir_enable_output  (ir_enable_output),
        .a_enable_input    (a_enable_input),
        .a_enable_output   (a_enable_output),
        .b_enable_input    (b_enable_input),
        .out_enable_input  (out_enable_input),
        .alu_enable_output (alu_enable_output),
        .alu_sub           (alu_sub),
        .t_state           (t_state),
        .halted            (halted)
    );

    task automatic set_fetch();
        e[0] = K_PCO | K_MARI;
        e[1] = K_PCI;
        e[2] = K_RAMO | K_IRI;
        e[3] = '0;
        e[4] = '0;
        e[5] = '0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        @(posedge Clock); #1;
        checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL reset_t_state got %b want 000001", t_state); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL reset_ctl got %h want 000", ctl); end
        Reset_n = 1'b1; #1;
        checks++; if (ctl !== (K_PCO | K_MARI)) begin errors++; $display("FAIL release_ctl got %h want %h", ctl, K_PCO | K_MARI); end
    endtask

    task automatic test_lda();
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; opcode = 4'b0001; #1;
        set_fetch();
        e[3] = K_IRO | K_MARI;
        e[4] = K_RAMO | K_AI;
        for (int k = 0; k < LDA_LEN; k++) begin
            checks++; if (t_state !== (6'b000001 << k)) begin errors++; $display("FAIL lda_t%0d_state got %b want %b", k + 1, t_state, 6'b000001 << k); end
            checks++; if (ctl !== e[k]) begin errors++; $display("FAIL lda_t%0d_ctl got %h want %h", k + 1, ctl, e[k]); end
            @(posedge Clock); #1;
        end
        checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL lda_retire got %b want 000001", t_state); end
    endtask

    task automatic test_alu();
        for (int s = 0; s < 2; s++) begin
            Reset_n = 1'b0; @(posedge Clock); #1;
            Reset_n = 1'b1; opcode = (s == 1) ? 4'b0011 : 4'b0010; #1;
            set_fetch();
            e[3] = K_IRO | K_MARI;
            e[4] = K_RAMO | K_BI | ((s == 1) ? K_SUB : 12'h000);
            e[5] = K_ALUO | K_AI | ((s == 1) ? K_SUB : 12'h000);
            for (int k = 0; k < 6; k++) begin
                checks++; if (t_state !== (6'b000001 << k)) begin errors++; $display("FAIL alu%0d_t%0d_state got %b want %b", s, k + 1, t_state, 6'b000001 << k); end
                checks++; if (ctl !== e[k]) begin errors++; $display("FAIL alu%0d_t%0d_ctl got %h want %h", s, k + 1, ctl, e[k]); end
                @(posedge Clock); #1;
            end
            checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL alu%0d_retire got %b want 000001", s, t_state); end
        end
    endtask

    task automatic test_out();
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; opcode = 4'b0100; #1;
        set_fetch();
        e[3] = K_AO | K_OUTI;
        for (int k = 0; k < OUT_LEN; k++) begin
            checks++; if (ctl !== e[k]) begin errors++; $display("FAIL out_t%0d_ctl got %h want %h", k + 1, ctl, e[k]); end
            @(posedge Clock); #1;
        end
        checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL out_retire got %b want 000001", t_state); end
    endtask

    task automatic test_nop();
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; opcode = 4'b0101; #1;
        set_fetch();
        for (int k = 0; k < NOP_LEN; k++) begin
            checks++; if (ctl !== e[k]) begin errors++; $display("FAIL nop_t%0d_ctl got %h want %h", k + 1, ctl, e[k]); end
            @(posedge Clock); #1;
        end
        checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL nop_retire got %b want 000001", t_state); end
    endtask

    task automatic test_halt();
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; opcode = 4'b1111; #1;
        set_fetch();
        for (int k = 0; k < 4; k++) begin
            checks++; if (ctl !== e[k] || halted !== 1'b0) begin errors++; $display("FAIL halt_t%0d got ctl %h halted %b want ctl %h halted 0", k + 1, ctl, halted, e[k]); end
            @(posedge Clock); #1;
        end
        for (int k = 0; k < 20; k++) begin
            checks++; if (halted !== 1'b1 || t_state !== 6'b000000 || ctl !== 12'h000) begin errors++; $display("FAIL halt_hold%0d got halted %b t %b ctl %h want 1 000000 000", k, halted, t_state, ctl); end
            @(posedge Clock); #1;
        end
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; #1;
        checks++; if (t_state !== 6'b000001 || halted !== 1'b0) begin errors++; $display("FAIL halt_reset got t %b halted %b want 000001 0", t_state, halted); end
        checks++; if (ctl !== (K_PCO | K_MARI)) begin errors++; $display("FAIL halt_refetch got %h want %h", ctl, K_PCO | K_MARI); end
    endtask

    task automatic test_reset_mid();
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1; opcode = 4'b0010;
        repeat (4) begin @(posedge Clock); #1; end
        checks++; if (t_state !== 6'b010000) begin errors++; $display("FAIL mid_at_t5 got %b want 010000", t_state); end
        Reset_n = 1'b0; #1;
        checks++; if (ctl !== 12'h000) begin errors++; $display("FAIL mid_ctl_in_reset got %h want 000", ctl); end
        @(posedge Clock); #1;
        checks++; if (t_state !== 6'b000001) begin errors++; $display("FAIL mid_t_state got %b want 000001", t_state); end
        Reset_n = 1'b1; #1;
        checks++; if (ctl !== (K_PCO | K_MARI) || a_enable_input !== 1'b0 || b_enable_input !== 1'b0) begin errors++; $display("FAIL mid_no_leak got %h want %h", ctl, K_PCO | K_MARI); end
    endtask

    task automatic test_random();
        int n = 0;
        int cyc = 0;
        Reset_n = 1'b0; @(posedge Clock); #1;
        Reset_n = 1'b1;
        while (n < 1000 && cyc < 20000) begin
            Reset_n = !halted;
            if (Reset_n && t_state == 6'b000001) begin
                opcode = 4'($urandom_range(15, 0));
                n++;
            end
            #1;
            checks++; if ($countones({pc_enable_output, ram_enable_output, ir_enable_output, a_enable_output, alu_enable_output}) > 1) begin errors++; $display("FAIL rand_bus cyc %0d got ctl %h want at most one driver", cyc, ctl); end
            checks++; if (halted ? (t_state !== 6'b000000) : ($countones(t_state) != 1)) begin errors++; $display("FAIL rand_tstate cyc %0d got t %b halted %b", cyc, t_state, halted); end
            @(posedge Clock); #1;
            cyc++;
        end
        checks++; if (n != 1000) begin errors++; $display("FAIL rand_budget got %0d instructions want 1000", n); end
    endtask

    initial begin
        test_reset();
        test_lda();
        test_alu();
        test_out();
        test_nop();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
